// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the issue-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  // Architectural register index.
  typedef logic [4:0] reg_idx_t;

  // Architectural register count (x0 is hardwired and never tracked).
  localparam int NUM_REGS = 32;

  // Reason(s) the decode instruction is being held, kept as one bundle for tracing.
  typedef struct packed {
    logic raw1;
    logic raw2;
    logic waw_full;
    logic cap_full;
  } hazard_cause_t;

endpackage

// File: rtl/hazard_scoreboard_reg_pending_ctr.sv
// Per-register outstanding-write counter: saturating up/down with a sticky
// underflow error (a retire seen while nothing is outstanding).
module hazard_scoreboard_reg_pending_ctr #(
  parameter int MAX_PEND = 3,
  localparam int W = $clog2(MAX_PEND + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         full,
  output logic         err
);

  logic [W-1:0] count_reg;
  logic         err_reg;
  logic         dec_ok;
  logic         inc_ok;

  assign zero   = (count_reg == '0);
  assign full   = (count_reg == W'(MAX_PEND));
  // A retire only counts when something is outstanding.
  assign dec_ok = dec && !zero;
  // Allocation into a full counter is only legal if a retire frees a slot this cycle.
  assign inc_ok = inc && (!full || dec_ok);

  assign count = count_reg;
  assign err   = err_reg;

  // Count update: simultaneous inc/dec cancel; underflow attempt latches err.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (inc_ok && !dec_ok) begin
        count_reg <= count_reg + W'(1);
      end else if (dec_ok && !inc_ok) begin
        count_reg <= count_reg - W'(1);
      end
      if (dec && zero) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage stall controller: tracks in-flight register writes, detects
// RAW/WAW/capacity hazards for the decode instruction, and drives stall/issue.
module hazard_scoreboard #(
  parameter int NUM_REGS     = hazard_scoreboard_pkg::NUM_REGS,
  parameter int MAX_PEND     = 3,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  id_valid,
  input  hazard_scoreboard_pkg::reg_idx_t       id_rs1,
  input  hazard_scoreboard_pkg::reg_idx_t       id_rs2,
  input  hazard_scoreboard_pkg::reg_idx_t       id_rd,
  input  logic                                  id_uses_rs1,
  input  logic                                  id_uses_rs2,
  input  logic                                  id_writes_rd,
  input  logic                                  wb_valid,
  input  hazard_scoreboard_pkg::reg_idx_t       wb_rd,
  input  logic                                  redirect,
  output logic                                  stall,
  output logic                                  issue,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
  output logic [CNT_W-1:0]                      stall_cycles,
  output logic                                  err
);

  import hazard_scoreboard_pkg::*;

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  // Per-register status; bit 0 describes x0 and is constant.
  logic [NUM_REGS-1:0] pend_zero;
  logic [NUM_REGS-1:0] eff_nz;
  logic [NUM_REGS-1:0] eff_full;
  logic [NUM_REGS-1:0] ctr_err;

  hazard_cause_t  cause;
  logic           front_ok;
  logic           alloc;
  logic           ret_any;
  logic [IW-1:0]  inflight_reg;
  logic [IW-1:0]  inflight_next;
  logic [IW-1:0]  inflight_eff;
  logic [CNT_W-1:0] stall_cycles_reg;

  // x0 never holds a pending write and never reports an error.
  assign pend_zero[0] = 1'b1;
  assign eff_nz[0]    = 1'b0;
  assign eff_full[0]  = 1'b0;
  assign ctr_err[0]   = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [PW-1:0] pend;
      logic          full;
      logic          wb_hit;
      logic          alloc_hit;

      assign wb_hit    = wb_valid && (wb_rd == reg_idx_t'(gi));
      assign alloc_hit = alloc && (id_rd == reg_idx_t'(gi));

      hazard_scoreboard_reg_pending_ctr #(
        .MAX_PEND (MAX_PEND)
      ) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (alloc_hit),
        .dec   (wb_hit),
        .count (pend),
        .zero  (pend_zero[gi]),
        .full  (full),
        .err   (ctr_err[gi])
      );

      // Effective pending count after a same-cycle writeback bypass.
      assign eff_nz[gi]   = !pend_zero[gi] && !(wb_hit && (pend == PW'(1)));
      assign eff_full[gi] = full && !wb_hit;
    end
  endgenerate

  // A writeback retires a tracked write only if that register has one outstanding.
  assign ret_any      = wb_valid && (wb_rd != '0) && !pend_zero[wb_rd];
  assign inflight_eff = inflight_reg - IW'(ret_any);

  // Hazard detection for the decode instruction.
  always_comb begin
    cause          = '0;
    cause.raw1     = id_uses_rs1 && (id_rs1 != '0) && eff_nz[id_rs1];
    cause.raw2     = id_uses_rs2 && (id_rs2 != '0) && eff_nz[id_rs2];
    cause.waw_full = id_writes_rd && (id_rd != '0) && eff_full[id_rd];
    cause.cap_full = id_writes_rd && (id_rd != '0) && (inflight_eff == IW'(MAX_INFLIGHT));
  end

  // Redirect squashes the decode slot, so it neither stalls nor issues.
  assign front_ok = !rst && id_valid && !redirect;
  assign stall    = front_ok && (cause != '0);
  assign issue    = front_ok && (cause == '0);
  assign alloc    = issue && id_writes_rd && (id_rd != '0);

  // Next total outstanding count; alloc and retire together leave it unchanged.
  always_comb begin
    inflight_next = inflight_reg;
    if (alloc && !ret_any) begin
      inflight_next = inflight_reg + IW'(1);
    end else if (ret_any && !alloc) begin
      inflight_next = inflight_reg - IW'(1);
    end
  end

  // Outstanding-write total and stall performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg     <= '0;
      stall_cycles_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
      if (stall) begin
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      end
    end
  end

  assign inflight     = inflight_reg;
  assign stall_cycles = stall_cycles_reg;
  // Each counter's flag is sticky and registered, so the OR is too.
  assign err          = |ctr_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard with a queue-based scoreboard.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_writes_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        redirect;
  logic        stall, issue;
  logic [2:0]  inflight;
  logic [31:0] stall_cycles;
  logic        err;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_writes_rd (id_writes_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .redirect     (redirect),
    .stall        (stall),
    .issue        (issue),
    .inflight     (inflight),
    .stall_cycles (stall_cycles),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, v;
    logic [4:0] rs1; logic u1;
    logic [4:0] rs2; logic u2;
    logic [4:0] rd;  logic w;
    logic       wbv; logic [4:0] wbrd;
    logic       redir;
  } stim_t;

  // Expected values: stall/issue for this cycle, registered outputs as seen
  // before this cycle's edge.
  typedef struct {
    string      name;
    logic       s, i;
    logic [31:0] inf, sc;
    logic       e;
  } exp_t;

  stim_t stims[$];
  exp_t  exps[$];
  exp_t  exp_q[$];
  exp_t  cur;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_txn = 0;

  function automatic void add(string name, logic r, logic v,
                              logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic w, logic wbv, logic [4:0] wbrd,
                              logic redir, logic s, logic i, int inf, int sc, logic e);
    stim_t st;
    exp_t  ex;
    st.rst = r; st.v = v; st.rs1 = rs1; st.u1 = u1; st.rs2 = rs2; st.u2 = u2;
    st.rd = rd; st.w = w; st.wbv = wbv; st.wbrd = wbrd; st.redir = redir;
    ex.name = name; ex.s = s; ex.i = i; ex.inf = 32'(inf); ex.sc = 32'(sc); ex.e = e;
    stims.push_back(st);
    exps.push_back(ex);
  endfunction

  task automatic chk(string tn, string field, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", tn, field, act, expv);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      $display("txn %0d %s stall=%b issue=%b inflight=%0d stall_cycles=%0d err=%b",
               n_txn, cur.name, stall, issue, inflight, stall_cycles, err);
      n_txn++;
      chk(cur.name, "stall",        32'(stall),  32'(cur.s));
      chk(cur.name, "issue",        32'(issue),  32'(cur.i));
      chk(cur.name, "inflight",     32'(inflight), cur.inf);
      chk(cur.name, "stall_cycles", stall_cycles, cur.sc);
      chk(cur.name, "err",          32'(err),    32'(cur.e));
    end
  end

  initial begin
    //   name               rst v rs1 u1 rs2 u2 rd w wbv wbrd rdr   s i inf sc e
    add("rst_hold",          1, 1, 5, 1, 0, 0, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    add("load_x5",           0, 1, 2, 1, 0, 0, 5, 1, 0, 0, 0,   0, 1, 0, 0, 0);
    add("add_raw_x5_a",      0, 1, 5, 1, 0, 0, 6, 0, 0, 0, 0,   1, 0, 1, 0, 0);
    add("add_raw_x5_b",      0, 1, 5, 1, 0, 0, 6, 0, 0, 0, 0,   1, 0, 1, 1, 0);
    add("add_wb_x5",         0, 1, 5, 1, 0, 0, 6, 0, 1, 5, 0,   0, 1, 1, 2, 0);
    add("write_x0",          0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0,   0, 1, 0, 2, 0);
    add("read_x0",           0, 1, 0, 1, 0, 1, 3, 0, 0, 0, 0,   0, 1, 0, 2, 0);
    add("wr_x1",             0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 1, 0, 2, 0);
    add("wr_x2",             0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0,   0, 1, 1, 2, 0);
    add("wr_x3",             0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   0, 1, 2, 2, 0);
    add("wr_x4",             0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0,   0, 1, 3, 2, 0);
    add("wr_x6_cap",         0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0,   1, 0, 4, 2, 0);
    add("wr_x6_cap_wb1",     0, 1, 0, 0, 0, 0, 6, 1, 1, 1, 0,   0, 1, 4, 3, 0);
    add("wb_x2",             0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0,   0, 0, 4, 3, 0);
    add("wb_x3",             0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,   0, 0, 3, 3, 0);
    add("wb_x4",             0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0,   0, 0, 2, 3, 0);
    add("wb_x6",             0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0,   0, 0, 1, 3, 0);
    add("wr_x7_a",           0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,   0, 1, 0, 3, 0);
    add("wr_x7_b",           0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,   0, 1, 1, 3, 0);
    add("wr_x7_c",           0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,   0, 1, 2, 3, 0);
    add("wr_x7_waw",         0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,   1, 0, 3, 3, 0);
    add("wr_x7_waw_wb7",     0, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0,   0, 1, 3, 4, 0);
    add("rd_x7_raw2",        0, 1, 0, 0, 7, 1, 8, 0, 0, 0, 0,   1, 0, 3, 4, 0);
    add("rd_x7_wb_a",        0, 1, 0, 0, 7, 1, 8, 0, 1, 7, 0,   1, 0, 3, 5, 0);
    add("rd_x7_wb_b",        0, 1, 0, 0, 7, 1, 8, 0, 1, 7, 0,   1, 0, 2, 6, 0);
    add("rd_x7_wb_c",        0, 1, 0, 0, 7, 1, 8, 0, 1, 7, 0,   0, 1, 1, 7, 0);
    add("wr_x8",             0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0,   0, 1, 0, 7, 0);
    add("rd_x8_redirect",    0, 1, 8, 1, 0, 0, 9, 0, 0, 0, 1,   0, 0, 1, 7, 0);
    add("rd_x8_stall",       0, 1, 8, 1, 0, 0, 9, 0, 0, 0, 0,   1, 0, 1, 7, 0);
    add("wb_x9_unalloc",     0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0,   0, 0, 1, 8, 0);
    add("idle_err",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 8, 1);
    add("wb_x0_ignored",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 8, 1);
    add("wr_x10",            0, 1, 0, 0, 0, 0,10, 1, 0, 0, 0,   0, 1, 1, 8, 1);
    add("wr_x11",            0, 1, 0, 0, 0, 0,11, 1, 0, 0, 0,   0, 1, 2, 8, 1);
    add("rd_x10_stall",      0, 1,10, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 3, 8, 1);
    add("rst_mid",           1, 1,10, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 9, 1);
    add("rd_x10_x11_post",   0, 1,10, 1,11, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
    add("idle_post",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_writes_rd = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; redirect = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < stims.size(); k++) begin
      @(posedge clk);
      #1;
      rst          = stims[k].rst;
      id_valid     = stims[k].v;
      id_rs1       = stims[k].rs1;
      id_uses_rs1  = stims[k].u1;
      id_rs2       = stims[k].rs2;
      id_uses_rs2  = stims[k].u2;
      id_rd        = stims[k].rd;
      id_writes_rd = stims[k].w;
      wb_valid     = stims[k].wbv;
      wb_rd        = stims[k].wbrd;
      redirect     = stims[k].redir;
      exp_q.push_back(exps[k]);
    end

    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
